elevator_controller: RTL and testbench

- Floor-scheduling controller for the 4-floor elevator.
- Latches floor-call buttons and decides up/down motion with collective (SCAN) scheduling.
- Times travel and door phases.
- Sequences the 4-bit status code that feeds the BCD-to-7-segment display decoder: 0 wait, 1–4 floor, 5 up, 6 open, 7 closed, 8 down. Code 9 is never emitted.

---
 rtl/elevator_pkg.sv | 57 +++++
 rtl/elevator_timer.sv | 44 ++++
 rtl/elevator_controller.sv | 229 ++++++++++++++++++++++
 tb/tb_elevator_controller.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the 4-floor elevator controller:
//   - state_t        : controller state encoding
//   - DIR_*          : travel direction encoding (dir register)
//   - CODE_*         : status codes sent to the BCD-to-7-segment decoder
//   - FLOOR_MIN/MAX  : legal floor range (floors are numbered 1..4)
//   - floor_bit / above_mask / below_mask : helpers mapping a floor number to
//     bit masks over the 4-bit call vector (bit i = floor i+1)
// -----------------------------------------------------------------------------
package elevator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_MOVE_UP    = 3'd1,
        ST_MOVE_DOWN  = 3'd2,
        ST_DOOR_OPEN  = 3'd3,
        ST_DOOR_CLOSE = 3'd4
    } state_t;

    localparam int         NUM_FLOORS = 4;
    localparam logic [2:0] FLOOR_MIN  = 3'd1;
    localparam logic [2:0] FLOOR_MAX  = 3'd4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [3:0] CODE_WAIT   = 4'd0;
    localparam logic [3:0] CODE_UP     = 4'd5;
    localparam logic [3:0] CODE_OPEN   = 4'd6;
    localparam logic [3:0] CODE_CLOSED = 4'd7;
    localparam logic [3:0] CODE_DOWN   = 4'd8;

    // One-hot call-vector bit for floor f (1..4).
    function automatic logic [3:0] floor_bit(input logic [2:0] f);
        return 4'b0001 << (f - 3'd1);
    endfunction

    // Call-vector bits for floors strictly above f.
    function automatic logic [3:0] above_mask(input logic [2:0] f);
        logic [3:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i + 1 > int'(f));
        end
        return m;
    endfunction

    // Call-vector bits for floors strictly below f.
    function automatic logic [3:0] below_mask(input logic [2:0] f);
        logic [3:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i + 1 < int'(f));
        end
        return m;
    endfunction

endpackage

// File: rtl/elevator_timer.sv
// -----------------------------------------------------------------------------
// elevator_timer
// Loadable down-counter. A load of N makes 'expired' high during the cycle
// before the N-th following clock edge, so logic sampling 'expired' acts
// exactly N edges after the load. Once expired and not reloaded, the counter
// rests at zero and stays quiet.
//   clk      : clock
//   reset    : synchronous active-high reset (count -> 0)
//   load     : load strobe (has priority over counting)
//   load_val : value to load
//   expired  : high while the count is 1 (decision point on the next edge)
// -----------------------------------------------------------------------------
module elevator_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == W'(1));

endmodule

// File: rtl/elevator_controller.sv
// -----------------------------------------------------------------------------
// elevator_controller
// SCAN-scheduled controller for a 4-floor elevator: latches call buttons,
// sequences motion and door phases, and produces the display status code.
//   clk         : system clock (posedge)
//   reset       : synchronous active-high reset
//   req[3:0]    : floor-call buttons, bit i = floor i+1
//   bcd[3:0]    : status code (0 wait, 1-4 floor, 5 up, 6 open, 7 closed, 8 down)
//   floor[2:0]  : current floor 1..4
//   pending[3:0]: latched outstanding calls
//   door_open, moving_up, moving_down : one-hot activity flags
// -----------------------------------------------------------------------------
module elevator_controller
    import elevator_pkg::*;
#(
    parameter int FLOOR_CYCLES = 50_000_000,
    parameter int DOOR_CYCLES  = 100_000_000,
    parameter int CLOSE_CYCLES = 50_000_000,
    parameter int ALT_CYCLES   = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] bcd,
    output logic [2:0] floor,
    output logic [3:0] pending,
    output logic       door_open,
    output logic       moving_up,
    output logic       moving_down
);
    localparam int MAX_AB     = (FLOOR_CYCLES > DOOR_CYCLES) ? FLOOR_CYCLES : DOOR_CYCLES;
    localparam int MAX_CD     = (CLOSE_CYCLES > ALT_CYCLES) ? CLOSE_CYCLES : ALT_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TW         = $clog2(MAX_CYCLES + 1);
    localparam int T_TRAVEL   = 0;
    localparam int T_DOOR     = 1;
    localparam int T_ALT      = 2;

    state_t     state_q, state_d;
    logic [2:0] floor_q, floor_d, next_floor;
    logic       dir_q, dir_d;
    logic [3:0] req_q;
    logic [3:0] pending_q, pending_d;
    logic [3:0] bcd_q, bcd_d, floor_code;
    logic       slot_q, slot_d;
    logic       alt_armed_q;
    logic       door_open_q, door_open_d;
    logic       moving_up_q, moving_up_d;
    logic       moving_down_q, moving_down_d;

    logic [3:0]    cur_bit, req_eff, clear_mask;
    logic          up_pend, down_pend, ahead, behind, state_change;
    logic          travel_load, door_load, alt_load;
    logic [TW-1:0] door_val;
    logic [2:0]    tmr_load, tmr_expired;
    logic [TW-1:0] tmr_val [3];

    assign tmr_load           = {alt_load, door_load, travel_load};
    assign tmr_val[T_TRAVEL]  = TW'(FLOOR_CYCLES);
    assign tmr_val[T_DOOR]    = door_val;
    assign tmr_val[T_ALT]     = TW'(ALT_CYCLES);

    // Travel, door/close and display-alternation timers.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_timer
            elevator_timer #(.W(TW)) u_timer (
                .clk      (clk),
                .reset    (reset),
                .load     (tmr_load[gi]),
                .load_val (tmr_val[gi]),
                .expired  (tmr_expired[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        dir_d       = dir_q;
        next_floor  = floor_q;
        travel_load = 1'b0;
        door_load   = 1'b0;
        door_val    = TW'(DOOR_CYCLES);
        clear_mask  = '0;
        ahead       = 1'b0;
        behind      = 1'b0;
        cur_bit     = floor_bit(floor_q);
        up_pend     = |(pending_q & above_mask(floor_q));
        down_pend   = |(pending_q & below_mask(floor_q));

        // A call for the floor whose door is already open just holds the door.
        req_eff = req_q;
        if (state_q == ST_DOOR_OPEN && (req_q & cur_bit) != '0) begin
            req_eff   = req_q & ~cur_bit;
            door_load = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if ((pending_q & cur_bit) != '0) begin
                    state_d    = ST_DOOR_OPEN;
                    clear_mask = cur_bit;
                    door_load  = 1'b1;
                end else if (up_pend) begin
                    state_d     = ST_MOVE_UP;
                    dir_d       = DIR_UP;
                    travel_load = 1'b1;
                end else if (down_pend) begin
                    state_d     = ST_MOVE_DOWN;
                    dir_d       = DIR_DOWN;
                    travel_load = 1'b1;
                end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (tmr_expired[T_TRAVEL]) begin
                    if (state_q == ST_MOVE_UP) begin
                        next_floor = (floor_q < FLOOR_MAX) ? floor_q + 3'd1 : floor_q;
                        ahead      = |(pending_q & above_mask(next_floor));
                    end else begin
                        next_floor = (floor_q > FLOOR_MIN) ? floor_q - 3'd1 : floor_q;
                        ahead      = |(pending_q & below_mask(next_floor));
                    end
                    floor_d = next_floor;
                    if ((pending_q & floor_bit(next_floor)) != '0) begin
                        state_d    = ST_DOOR_OPEN;
                        clear_mask = floor_bit(next_floor);
                        door_load  = 1'b1;
                    end else if (ahead) begin
                        travel_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DOOR_OPEN: begin
                // A hold request on the expiry edge keeps the door open.
                if (!door_load && tmr_expired[T_DOOR]) begin
                    state_d   = ST_DOOR_CLOSE;
                    door_load = 1'b1;
                    door_val  = TW'(CLOSE_CYCLES);
                end
            end
            ST_DOOR_CLOSE: begin
                ahead  = (dir_q == DIR_UP) ? up_pend : down_pend;
                behind = (dir_q == DIR_UP) ? down_pend : up_pend;
                if ((req_q & cur_bit) != '0) begin
                    state_d    = ST_DOOR_OPEN;
                    clear_mask = cur_bit;
                    door_load  = 1'b1;
                end else if (tmr_expired[T_DOOR]) begin
                    if (ahead || behind) begin
                        dir_d       = ahead ? dir_q : ~dir_q;
                        state_d     = ((ahead ? dir_q : ~dir_q) == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
                        travel_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pending_d = (pending_q | req_eff) & ~clear_mask;

        // Display: every state change restarts on the status-code slot; the
        // first edge after reset arms the free-running alternation.
        state_change = (state_d != state_q);
        alt_load     = state_change | tmr_expired[T_ALT] | ~alt_armed_q;
        if (state_change) begin
            slot_d = 1'b0;
        end else if (tmr_expired[T_ALT]) begin
            slot_d = ~slot_q;
        end else begin
            slot_d = slot_q;
        end

        floor_code = {1'b0, floor_d};
        case (state_d)
            ST_MOVE_UP:    bcd_d = slot_d ? floor_code : CODE_UP;
            ST_MOVE_DOWN:  bcd_d = slot_d ? floor_code : CODE_DOWN;
            ST_DOOR_OPEN:  bcd_d = CODE_OPEN;
            ST_DOOR_CLOSE: bcd_d = CODE_CLOSED;
            default:       bcd_d = slot_d ? floor_code : CODE_WAIT;
        endcase

        door_open_d   = (state_d == ST_DOOR_OPEN);
        moving_up_d   = (state_d == ST_MOVE_UP);
        moving_down_d = (state_d == ST_MOVE_DOWN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            floor_q       <= FLOOR_MIN;
            dir_q         <= DIR_UP;
            req_q         <= '0;
            pending_q     <= '0;
            bcd_q         <= CODE_WAIT;
            slot_q        <= 1'b0;
            alt_armed_q   <= 1'b0;
            door_open_q   <= 1'b0;
            moving_up_q   <= 1'b0;
            moving_down_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            floor_q       <= floor_d;
            dir_q         <= dir_d;
            req_q         <= req;
            pending_q     <= pending_d;
            bcd_q         <= bcd_d;
            slot_q        <= slot_d;
            alt_armed_q   <= 1'b1;
            door_open_q   <= door_open_d;
            moving_up_q   <= moving_up_d;
            moving_down_q <= moving_down_d;
        end
    end

    assign bcd         = bcd_q;
    assign floor       = floor_q;
    assign pending     = pending_q;
    assign door_open   = door_open_q;
    assign moving_up   = moving_up_q;
    assign moving_down = moving_down_q;

endmodule

// File: tb/tb_elevator_controller.sv
// -----------------------------------------------------------------------------
// tb_elevator_controller
// Directed scenarios followed by random calls, all cycle-checked against a
// behavioural elevator model that tracks mode, floor, remaining phase time and
// time spent in the current mode.
// -----------------------------------------------------------------------------
module tb_elevator_controller;
    localparam int FLOOR = 4;
    localparam int DOOR  = 6;
    localparam int CLOSE = 3;
    localparam int ALT   = 2;

    localparam int M_WAIT  = 0;
    localparam int M_UP    = 1;
    localparam int M_DOWN  = 2;
    localparam int M_OPEN  = 3;
    localparam int M_CLOSE = 4;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] bcd;
    logic [2:0] floor;
    logic [3:0] pending;
    logic       door_open;
    logic       moving_up;
    logic       moving_down;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    int       m_mode;
    int       m_floor;
    int       m_left;
    int       m_age;
    bit       m_goes_up;
    bit [3:0] m_pend;
    bit [3:0] m_samp;

    elevator_controller #(
        .FLOOR_CYCLES (FLOOR),
        .DOOR_CYCLES  (DOOR),
        .CLOSE_CYCLES (CLOSE),
        .ALT_CYCLES   (ALT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .bcd         (bcd),
        .floor       (floor),
        .pending     (pending),
        .door_open   (door_open),
        .moving_up   (moving_up),
        .moving_down (moving_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit any_above(input bit [3:0] p, input int f);
        for (int i = f + 1; i <= 4; i++) if (p[i-1]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_below(input bit [3:0] p, input int f);
        for (int i = 1; i < f; i++) if (p[i-1]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_bcd();
        int slot;
        slot = (m_age < 0) ? 0 : (m_age / ALT) % 2;
        case (m_mode)
            M_OPEN:  return 6;
            M_CLOSE: return 7;
            M_UP:    return (slot != 0) ? m_floor : 5;
            M_DOWN:  return (slot != 0) ? m_floor : 8;
            default: return (slot != 0) ? m_floor : 0;
        endcase
    endfunction

    task automatic model_open();
        m_mode = M_OPEN;
        m_left = DOOR;
        m_pend[m_floor-1] = 1'b0;
    endtask

    // Advance the model across one rising edge.
    task automatic model_step(input bit [3:0] r, input bit rst);
        bit [3:0] s;
        bit [3:0] p;
        int       prev;
        bit       fwd;
        bit       rev;
        if (rst) begin
            m_mode = M_WAIT; m_floor = 1; m_pend = '0; m_goes_up = 1'b1;
            m_left = 0; m_age = -1; m_samp = '0;
            return;
        end
        s = m_samp;            // button sample taken on the previous edge
        m_samp = r;
        p = m_pend;            // decisions use calls latched before this edge
        prev = m_mode;
        m_pend = m_pend | s;
        case (m_mode)
            M_WAIT: begin
                if (p[m_floor-1]) model_open();
                else if (any_above(p, m_floor)) begin m_mode = M_UP; m_goes_up = 1'b1; m_left = FLOOR; end
                else if (any_below(p, m_floor)) begin m_mode = M_DOWN; m_goes_up = 1'b0; m_left = FLOOR; end
            end
            M_UP, M_DOWN: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor += (m_mode == M_UP) ? 1 : -1;
                    if (p[m_floor-1]) model_open();
                    else if ((m_mode == M_UP) ? any_above(p, m_floor) : any_below(p, m_floor)) m_left = FLOOR;
                    else m_mode = M_WAIT;
                end
            end
            M_OPEN: begin
                if (s[m_floor-1]) begin
                    m_left = DOOR;
                    m_pend[m_floor-1] = p[m_floor-1];
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_mode = M_CLOSE; m_left = CLOSE; end
                end
            end
            default: begin // M_CLOSE
                if (s[m_floor-1]) model_open();
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        fwd = m_goes_up ? any_above(p, m_floor) : any_below(p, m_floor);
                        rev = m_goes_up ? any_below(p, m_floor) : any_above(p, m_floor);
                        if (fwd || rev) begin
                            if (rev && !fwd) m_goes_up = ~m_goes_up;
                            m_mode = m_goes_up ? M_UP : M_DOWN;
                            m_left = FLOOR;
                        end else m_mode = M_WAIT;
                    end
                end
            end
        endcase
        m_age = (m_mode != prev) ? 0 : m_age + 1;
    endtask

    // Drive one cycle (called at a falling edge), then check every output.
    task automatic cycle(input logic [3:0] r, input logic rst);
        req = r;
        reset = rst;
        model_step(r, rst);
        @(posedge clk);
        @(negedge clk);
        chk("bcd", bcd, exp_bcd());
        chk("floor", floor, m_floor);
        chk("pending", pending, m_pend);
        chk("door_open", door_open, m_mode == M_OPEN);
        chk("moving_up", moving_up, m_mode == M_UP);
        chk("moving_down", moving_down, m_mode == M_DOWN);
    endtask

    initial begin
        int       door_floors[$];
        bit       prev_door;
        bit       found;
        int       cnt;
        int       md_cycles;
        bit [3:0] alt_seq [6];
        bit [3:0] r;

        alt_seq = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0};
        reset = 1'b1;
        req = '0;
        @(negedge clk);

        // Reset and idle alternation.
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        chk("rst_bcd", bcd, 0);
        chk("rst_floor", floor, 1);
        chk("rst_pending", pending, 0);
        chk("rst_flags", {door_open, moving_up, moving_down}, 0);
        for (int k = 0; k < 6; k++) begin
            cycle(4'b0000, 1'b0);
            chk("idle_alt", bcd, alt_seq[k]);
        end

        // Call to floor 3: request sampled at edge 0.
        cycle(4'b0100, 1'b0);
        for (int e = 1; e <= 20; e++) begin
            cycle(4'b0000, 1'b0);
            if (e == 1)  chk("c3_pending", pending, 4'b0100);
            if (e == 2)  chk("c3_up", {moving_up, bcd}, {1'b1, 4'd5});
            if (e == 6)  chk("c3_floor2", floor, 2);
            if (e == 10) chk("c3_open", {floor, door_open, bcd, pending}, {3'd3, 1'b1, 4'd6, 4'd0});
            if (e == 16) chk("c3_close", {door_open, bcd}, {1'b0, 4'd7});
            if (e == 19) chk("c3_idle", {moving_up, moving_down, door_open, bcd}, 0);
        end

        // Collective service of floors 2 and 4 from floor 1.
        cycle(4'b0000, 1'b1);
        cycle(4'b1010, 1'b0);
        prev_door = 1'b0;
        md_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            cycle(4'b0000, 1'b0);
            if (door_open && !prev_door) door_floors.push_back(int'(floor));
            if (moving_down) md_cycles++;
            prev_door = door_open;
        end
        chk("col_stops", door_floors.size(), 2);
        if (door_floors.size() == 2) begin
            chk("col_first", door_floors[0], 2);
            chk("col_second", door_floors[1], 4);
        end
        chk("col_no_down", md_cycles, 0);
        chk("col_end", {floor, door_open, moving_up}, {3'd4, 2'b00});

        // Reversal: 2 -> 4 with a floor-1 call made during travel.
        cycle(4'b0000, 1'b1);
        cycle(4'b0010, 1'b0);
        for (int k = 0; k < 16; k++) cycle(4'b0000, 1'b0);
        cycle(4'b1000, 1'b0);
        for (int k = 0; k < 4; k++) cycle(4'b0000, 1'b0);
        cycle(4'b0001, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            cycle(4'b0000, 1'b0);
            if (moving_down === 1'b1) found = 1'b1;
        end
        chk("rev_reached", found, 1);
        chk("rev_start", {floor, bcd}, {3'd4, 4'd8});
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);
        chk("rev_alt_floor", bcd, 4);

        // Door reopen during the closing phase at floor 1.
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            cycle(4'b0000, 1'b0);
            if (bcd === 4'd7) found = 1'b1;
        end
        chk("reopen_close_seen", found, 1);
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        chk("reopen_open", {door_open, bcd}, {1'b1, 4'd6});
        cnt = 1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(4'b0000, 1'b0);
            if (door_open === 1'b1) cnt++;
            else found = 1'b1;
        end
        chk("reopen_len", cnt, DOOR);

        // Calls above and below at once from floor 2: up wins.
        for (int k = 0; k < 5; k++) cycle(4'b0000, 1'b0);
        cycle(4'b0010, 1'b0);
        for (int k = 0; k < 16; k++) cycle(4'b0000, 1'b0);
        cycle(4'b1001, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);
        chk("tie_up", {moving_up, moving_down}, 2'b10);

        // Reset while moving down through floor 3.
        found = 1'b0;
        for (int k = 0; k < 80 && !found; k++) begin
            cycle(4'b0000, 1'b0);
            if (moving_down === 1'b1 && floor === 3'd3) found = 1'b1;
        end
        chk("mid_reached", found, 1);
        cycle(4'b0000, 1'b1);
        chk("mid_rst", {floor, pending, bcd, door_open, moving_up, moving_down},
            {3'd1, 4'd0, 4'd0, 3'b000});

        // Random calls with occasional resets.
        for (int k = 0; k < 500; k++) begin
            r = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            cycle(r, $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
